instr_fetch_unit: RTL and testbench

Sequencer that sits directly upstream of the processor control unit. It holds the program counter and reads 16-bit instruction words from a synchronous instruction ROM. It presents each word on `instruction` with a one-cycle `run` pulse, then holds the word stable until the control unit returns `done`. It detects a HALT word, supports a graceful stop request, and flags a stuck control unit with a watchdog.

---
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch sequencer, its instruction ROM and the control unit.
// The sequencer takes the master view; the surrounding system takes the slave view.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic [15:0]       instruction;
  logic              run;
  logic              done;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       retired;
  logic              busy;
  logic              halted;
  logic              error;

  modport master (
    input  start, stop, mem_rdata, done,
    output mem_addr, instruction, run, pc, retired, busy, halted, error
  );

  modport slave (
    output start, stop, mem_rdata, done,
    input  mem_addr, instruction, run, pc, retired, busy, halted, error
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: walks the PC through a synchronous ROM, issues each word
// to the control unit with a run pulse, and handles HALT words, stop requests and a watchdog.
module instr_fetch_unit #(
  parameter int          ADDR_W    = 5,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter int          TIMEOUT   = 15
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    WAIT,
    HALTED
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_memAddr;
  logic [15:0]       r_instruction;
  logic [15:0]       r_retired;
  logic              r_run;
  logic              r_busy;
  logic              r_halted;
  logic              r_error;
  logic              r_stopPending;
  logic [WD_W-1:0]   r_wdCount;

  logic [ADDR_W-1:0] w_pcNext;
  logic              w_stopReq;

  assign w_pcNext  = r_pc + ADDR_W'(1);
  assign w_stopReq = r_stopPending | bus.stop;

  // mem_addr is loaded on the edge entering FETCH so the ROM sees it during FETCH
  // and its registered data is ready to capture at the end of LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc          <= '0;
      r_memAddr     <= '0;
      r_instruction <= '0;
      r_retired     <= '0;
      r_run         <= 1'b0;
      r_busy        <= 1'b0;
      r_halted      <= 1'b0;
      r_error       <= 1'b0;
      r_stopPending <= 1'b0;
      r_wdCount     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= FETCH;
            r_memAddr <= r_pc;
            r_busy    <= 1'b1;
          end
        end

        FETCH: begin
          if (bus.stop) r_stopPending <= 1'b1;
          r_state <= LOAD;
        end

        LOAD: begin
          if (bus.mem_rdata == HALT_WORD) begin
            r_state       <= HALTED;
            r_halted      <= 1'b1;
            r_busy        <= 1'b0;
            r_stopPending <= 1'b0;
          end else begin
            if (bus.stop) r_stopPending <= 1'b1;
            r_instruction <= bus.mem_rdata;
            r_run         <= 1'b1;
            r_state       <= ISSUE;
          end
        end

        ISSUE: begin
          if (bus.stop) r_stopPending <= 1'b1;
          r_run     <= 1'b0;
          r_wdCount <= '0;
          r_state   <= WAIT;
        end

        // A stop arriving together with done still lets the instruction retire first.
        WAIT: begin
          if (bus.done) begin
            r_pc      <= w_pcNext;
            r_retired <= r_retired + 16'd1;
            if (w_stopReq) begin
              r_state       <= IDLE;
              r_busy        <= 1'b0;
              r_stopPending <= 1'b0;
            end else begin
              r_state   <= FETCH;
              r_memAddr <= w_pcNext;
            end
          end else if (r_wdCount == WD_LAST) begin
            r_error       <= 1'b1;
            r_state       <= HALTED;
            r_halted      <= 1'b1;
            r_busy        <= 1'b0;
            r_stopPending <= 1'b0;
          end else begin
            if (bus.stop) r_stopPending <= 1'b1;
            r_wdCount <= r_wdCount + WD_W'(1);
          end
        end

        HALTED: begin
          if (bus.start) begin
            r_pc      <= '0;
            r_retired <= '0;
            r_error   <= 1'b0;
            r_memAddr <= '0;
            r_halted  <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= FETCH;
          end
        end

        default: begin
          r_state  <= IDLE;
          r_run    <= 1'b0;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr    = r_memAddr;
  assign bus.instruction = r_instruction;
  assign bus.run         = r_run;
  assign bus.pc          = r_pc;
  assign bus.retired     = r_retired;
  assign bus.busy        = r_busy;
  assign bus.halted      = r_halted;
  assign bus.error       = r_error;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a ROM model plus a linear script of
// straight-line, watchdog, stop/resume, PC wrap, spurious-done and reset scenarios.
module tb_instr_fetch_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   runCount = 0;
  int   runBase;
  logic [15:0] expRetired;
  logic [15:0] rom [32];

  instr_fetch_unit_if #(.ADDR_W(5)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (5),
    .HALT_WORD(16'hFFFF),
    .TIMEOUT  (15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data for the address seen at an edge is valid after that edge.
  always @(posedge clk) bus.mem_rdata <= rom[bus.mem_addr];

  always @(posedge clk) if (bus.run) runCount <= runCount + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called while in FETCH for addr; retires one instruction with done in the 2nd WAIT cycle.
  task automatic applyStimulus(input logic [4:0] addr, input logic [15:0] instr);
    logic [4:0] nxt;
    nxt = addr + 5'd1;
    checkOutput("fetch_addr", bus.mem_addr, addr);
    tick(2);
    checkOutput("issue_run", bus.run, 1);
    checkOutput("issue_instr", bus.instruction, instr);
    tick(2);
    checkOutput("wait_instr", bus.instruction, instr);
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    expRetired = expRetired + 16'd1;
    checkOutput("retired", bus.retired, expRetired);
    checkOutput("pc_next", bus.pc, nxt);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    expRetired = 16'd0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h0100 + 16'(i);
    rom[0] = 16'h2000;
    rom[1] = 16'h4000;
    rom[2] = 16'hFFFF;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.done = 1'b0;
    tick(2);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_halted", bus.halted, 0);
    checkOutput("rst_pc", bus.pc, 0);
    checkOutput("rst_instr", bus.instruction, 0);
    checkOutput("rst_run", bus.run, 0);
    reset = 1'b0;
    tick(1);

    $display("[TB] straight-line program");
    runBase = runCount;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    checkOutput("s1_busy", bus.busy, 1);
    applyStimulus(5'd0, 16'h2000);
    applyStimulus(5'd1, 16'h4000);
    tick(2);
    checkOutput("s1_halted", bus.halted, 1);
    checkOutput("s1_busy_end", bus.busy, 0);
    checkOutput("s1_pc", bus.pc, 2);
    checkOutput("s1_retired", bus.retired, 2);
    checkOutput("s1_instr_kept", bus.instruction, 16'h4000);
    checkOutput("s1_run_pulses", runCount - runBase, 2);

    $display("[TB] watchdog");
    rom[0] = 16'h1234;
    rom[1] = 16'h1111;
    rom[2] = 16'h2222;
    rom[3] = 16'h3333;
    rom[4] = 16'h4444;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    expRetired = 16'd0;
    checkOutput("wd_retired_clr", bus.retired, 0);
    checkOutput("wd_pc_clr", bus.pc, 0);
    tick(2);
    checkOutput("wd_run", bus.run, 1);
    tick(15);
    checkOutput("wd_not_yet", bus.error, 0);
    checkOutput("wd_still_busy", bus.busy, 1);
    tick(1);
    checkOutput("wd_error", bus.error, 1);
    checkOutput("wd_halted", bus.halted, 1);
    checkOutput("wd_retired", bus.retired, 0);
    checkOutput("wd_pc", bus.pc, 0);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    checkOutput("wd_error_clr", bus.error, 0);
    checkOutput("wd_halted_clr", bus.halted, 0);

    $display("[TB] stop and resume");
    applyStimulus(5'd0, 16'h1234);
    applyStimulus(5'd1, 16'h1111);
    applyStimulus(5'd2, 16'h2222);
    checkOutput("sr_addr3", bus.mem_addr, 3);
    tick(1);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    checkOutput("sr_run", bus.run, 1);
    checkOutput("sr_instr", bus.instruction, 16'h3333);
    tick(2);
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    expRetired = expRetired + 16'd1;
    checkOutput("sr_idle_busy", bus.busy, 0);
    checkOutput("sr_pc", bus.pc, 4);
    checkOutput("sr_retired", bus.retired, expRetired);
    bus.done = 1'b1;
    bus.stop = 1'b1;
    tick(3);
    bus.done = 1'b0;
    bus.stop = 1'b0;
    checkOutput("idle_done_ignored", bus.retired, expRetired);
    checkOutput("idle_stays", bus.busy, 0);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    applyStimulus(5'd4, 16'h4444);

    $display("[TB] pc wrap");
    for (int i = 5; i < 30; i++) applyStimulus(5'(i), 16'h0100 + 16'(i));
    tick(2);
    checkOutput("wrap_instr30", bus.instruction, 16'h011E);
    tick(1);
    bus.done = 1'b1;
    bus.stop = 1'b1;
    tick(1);
    bus.done = 1'b0;
    bus.stop = 1'b0;
    expRetired = expRetired + 16'd1;
    checkOutput("wrap_idle", bus.busy, 0);
    checkOutput("wrap_pc31", bus.pc, 31);
    checkOutput("wrap_retired30", bus.retired, expRetired);
    rom[0] = 16'hFFFF;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    applyStimulus(5'd31, 16'h011F);
    checkOutput("wrap_memaddr0", bus.mem_addr, 0);
    tick(2);
    checkOutput("wrap_halted", bus.halted, 1);
    checkOutput("wrap_retired", bus.retired, 16'd32);

    $display("[TB] spurious done");
    rom[0] = 16'h7000;
    rom[5] = 16'h6000;
    bus.done = 1'b1;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    expRetired = 16'd0;
    checkOutput("sp_fetch_ret", bus.retired, 0);
    tick(1);
    checkOutput("sp_load_ret", bus.retired, 0);
    checkOutput("sp_load_instr", bus.instruction, 16'h011F);
    tick(1);
    checkOutput("sp_issue_ret", bus.retired, 0);
    checkOutput("sp_issue_instr", bus.instruction, 16'h7000);
    tick(1);
    checkOutput("sp_wait_ret", bus.retired, 0);
    tick(1);
    bus.done = 1'b0;
    expRetired = 16'd1;
    checkOutput("sp_retired", bus.retired, expRetired);
    checkOutput("sp_pc", bus.pc, 1);

    $display("[TB] reset mid-wait");
    applyStimulus(5'd1, 16'h1111);
    applyStimulus(5'd2, 16'h2222);
    applyStimulus(5'd3, 16'h3333);
    applyStimulus(5'd4, 16'h4444);
    tick(4);
    checkOutput("rw_instr", bus.instruction, 16'h6000);
    checkOutput("rw_pc", bus.pc, 5);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rw_instr0", bus.instruction, 0);
    checkOutput("rw_pc0", bus.pc, 0);
    checkOutput("rw_retired0", bus.retired, 0);
    checkOutput("rw_memaddr0", bus.mem_addr, 0);
    checkOutput("rw_run0", bus.run, 0);
    checkOutput("rw_busy0", bus.busy, 0);
    checkOutput("rw_halted0", bus.halted, 0);
    checkOutput("rw_error0", bus.error, 0);
    tick(2);
    reset = 1'b0;
    runBase = runCount;
    tick(5);
    checkOutput("rw_no_run", runCount - runBase, 0);
    checkOutput("rw_idle", bus.busy, 0);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(2);
    checkOutput("rw_restart_run", bus.run, 1);
    checkOutput("rw_restart_instr", bus.instruction, 16'h7000);
    checkOutput("rw_restart_pc", bus.pc, 0);
    tick(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
